// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared constants and types for the fetch/decode hold logic:
//             NOP encoding, pipeline state encoding, default control width.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          CTRL_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_hold_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_hold_ctrl_if
//  Purpose  : Hazard/branch controls, fetch word and decode bundle going into
//             the fetch hold controller, plus its PC, IF/ID, ID/EX and status
//             outputs. Optional macro PERF_CNT_EN adds the perf counters.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_hold_ctrl_if #(
  parameter int CTRL_W = pipe_pkg::CTRL_W_DEF
);
  logic              hold_pc;
  logic              hold_if_id;
  logic              bubble_sel;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic [31:0]       imem_instr;
  logic [CTRL_W-1:0] id_ctrl_in;
  logic [31:0]       pc;
  logic [31:0]       if_id_pc4;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic [1:0]        state;
  logic              stall_err;
`ifdef PERF_CNT_EN
  logic [31:0]       perf_stalls;
  logic [31:0]       perf_flushes;
`endif

  // Driver side: hazard detector, decode stage and instruction memory
  modport master (
    output hold_pc, hold_if_id, bubble_sel, branch_taken, branch_target,
    output imem_instr, id_ctrl_in,
`ifdef PERF_CNT_EN
    input  perf_stalls, perf_flushes,
`endif
    input  pc, if_id_pc4, if_id_instr, if_id_valid, id_ex_ctrl, state, stall_err
  );

  // Controller side
  modport slave (
    input  hold_pc, hold_if_id, bubble_sel, branch_taken, branch_target,
    input  imem_instr, id_ctrl_in,
`ifdef PERF_CNT_EN
    output perf_stalls, perf_flushes,
`endif
    output pc, if_id_pc4, if_id_instr, if_id_valid, id_ex_ctrl, state, stall_err
  );
endinterface
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_reg
//  Purpose  : Pipeline register with load enable, synchronous clear (only
//             when enabled) and asynchronous reset to RESET_VAL.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en,
  input  wire logic             clr,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  // Hold when disabled; clear wins over load when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= RESET_VAL;
    else if (en)  q <= clr ? RESET_VAL : d;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_hold_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_hold_ctrl
//  Purpose  : Owns PC, IF/ID and ID/EX control registers; applies load-use
//             holds/bubbles and branch redirect/flush. Tracks RUN/STALL/FLUSH
//             and flags over-long stall runs. Optional macro PERF_CNT_EN
//             adds saturating stall-cycle and redirect counters.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_hold_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = CTRL_W_DEF,
  parameter int          MAX_STALL = 4
) (
  input wire logic         clk,
  input wire logic         rst_n,
  fetch_hold_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_STALL + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_STALL + 1);

  logic [31:0]      pc_q;
  logic [31:0]      pc_plus4;
  logic             redirect;
  state_t           state_q;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_err_q;
  logic [64:0]      if_id_q;

  assign pc_plus4 = pc_q + 32'd4;                  // wraps modulo 2^32
  assign redirect = bus.branch_taken & ~bus.hold_pc; // a held PC ignores branches

  // PC: hold > branch redirect > sequential
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             pc_q <= RESET_PC;
    else if (bus.hold_pc)   pc_q <= pc_q;
    else if (redirect)      pc_q <= bus.branch_target;
    else                    pc_q <= pc_plus4;
  end

  // IF/ID: {valid, pc4, instr}; a redirect squashes the wrong-path fetch
  pipe_reg #(
    .WIDTH     (65),
    .RESET_VAL ({1'b0, 32'h0, NOP_INSTR})
  ) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~bus.hold_if_id),
    .clr   (redirect),
    .d     ({1'b1, pc_plus4, bus.imem_instr}),
    .q     (if_id_q)
  );

  // ID/EX control: bubble inserts all-zero control, unrelated to branches
  pipe_reg #(
    .WIDTH     (CTRL_W),
    .RESET_VAL ('0)
  ) u_id_ex (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (bus.bubble_sel),
    .d     (bus.id_ctrl_in),
    .q     (bus.id_ex_ctrl)
  );

  // Pipeline state, stall-run counter and sticky stall error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stall_cnt   <= '0;
      stall_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN, ST_STALL, ST_FLUSH: begin
          if (bus.hold_pc)           state_q <= ST_STALL;
          else if (bus.branch_taken) state_q <= ST_FLUSH;
          else                       state_q <= ST_RUN;
        end
        default:                     state_q <= ST_RUN;
      endcase
      if (bus.hold_pc) begin
        if (stall_cnt != CNT_SAT) stall_cnt <= stall_cnt + CNT_W'(1);
        if (stall_cnt >= CNT_W'(MAX_STALL)) stall_err_q <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] perf_stalls_q;
  logic [31:0] perf_flushes_q;

  // Saturating counts of held-PC cycles and accepted redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stalls_q  <= 32'h0;
      perf_flushes_q <= 32'h0;
    end else begin
      if (bus.hold_pc && perf_stalls_q != 32'hFFFF_FFFF)
        perf_stalls_q <= perf_stalls_q + 32'd1;
      if (redirect && perf_flushes_q != 32'hFFFF_FFFF)
        perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign bus.perf_stalls  = perf_stalls_q;
  assign bus.perf_flushes = perf_flushes_q;
`endif

  assign bus.pc          = pc_q;
  assign bus.if_id_valid = if_id_q[64];
  assign bus.if_id_pc4   = if_id_q[63:32];
  assign bus.if_id_instr = if_id_q[31:0];
  assign bus.state       = state_q;
  assign bus.stall_err   = stall_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_hold_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_hold_ctrl
//  Purpose  : Self-checking bench for fetch_hold_ctrl with a cycle-level
//             reference model and directed scenarios. Honors PERF_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_hold_ctrl;

  localparam int CTRL_W    = 10;
  localparam int MAX_STALL = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  fetch_hold_ctrl_if #(.CTRL_W(CTRL_W)) bus ();

  fetch_hold_ctrl #(
    .RESET_PC  (32'h0),
    .CTRL_W    (CTRL_W),
    .MAX_STALL (MAX_STALL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0]       m_pc, m_pc4, m_instr, m_state;
  logic              m_valid, m_err;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_run;
  longint            m_stalls, m_flushes;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    m_ctrl = '0; m_state = 32'd0; m_run = 0; m_err = 1'b0;
    m_stalls = 0; m_flushes = 0;
  endtask

  // One clock: derive the next architectural state from the rules, then step
  task automatic cyc();
    logic [31:0] n_pc, n_pc4, n_instr, n_state;
    logic n_valid;
    logic [CTRL_W-1:0] n_ctrl;
    bit take;
    take    = bus.branch_taken && !bus.hold_pc;
    n_pc    = bus.hold_pc ? m_pc : (take ? bus.branch_target : m_pc + 32'd4);
    n_pc4   = m_pc4; n_instr = m_instr; n_valid = m_valid;
    if (!bus.hold_if_id) begin
      if (take) begin n_pc4 = 0; n_instr = 0; n_valid = 0; end
      else begin n_pc4 = m_pc + 32'd4; n_instr = bus.imem_instr; n_valid = 1; end
    end
    n_ctrl  = bus.bubble_sel ? '0 : bus.id_ctrl_in;
    n_state = bus.hold_pc ? 32'd1 : (bus.branch_taken ? 32'd2 : 32'd0);
    @(posedge clk);
    #1;
    m_pc = n_pc; m_pc4 = n_pc4; m_instr = n_instr; m_valid = n_valid;
    m_ctrl = n_ctrl; m_state = n_state;
    m_run = bus.hold_pc ? m_run + 1 : 0;
    if (m_run >= MAX_STALL + 1) m_err = 1'b1;
    if (bus.hold_pc && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    if (take && m_flushes < 64'hFFFF_FFFF) m_flushes++;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", bus.pc, m_pc);
      chk("if_id_pc4", bus.if_id_pc4, m_pc4);
      chk("if_id_instr", bus.if_id_instr, m_instr);
      chk("if_id_valid", {31'b0, bus.if_id_valid}, {31'b0, m_valid});
      chk("id_ex_ctrl", {22'b0, bus.id_ex_ctrl}, {22'b0, m_ctrl});
      chk("state", {30'b0, bus.state}, m_state);
      chk("stall_err", {31'b0, bus.stall_err}, {31'b0, m_err});
`ifdef PERF_CNT_EN
      chk("perf_stalls", bus.perf_stalls, m_stalls[31:0]);
      chk("perf_flushes", bus.perf_flushes, m_flushes[31:0]);
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.hold_pc = 0; bus.hold_if_id = 0; bus.bubble_sel = 0; bus.branch_taken = 0;
    bus.branch_target = 32'h0; bus.imem_instr = 32'h8C01_0004; bus.id_ctrl_in = 10'h2A5;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_valid", {31'b0, bus.if_id_valid}, 32'h0);
    chk("rst_err", {31'b0, bus.stall_err}, 32'h0);

    // 1: free run
    cyc();
    chk("t1_pc", bus.pc, 32'h4);
    chk("t1_instr", bus.if_id_instr, 32'h8C01_0004);
    chk("t1_pc4", bus.if_id_pc4, 32'h4);
    chk("t1_valid", {31'b0, bus.if_id_valid}, 32'h1);
    chk("t1_ctrl", {22'b0, bus.id_ex_ctrl}, 32'h2A5);
    cyc();
    chk("t1_pc8", bus.pc, 32'h8);

    // 2: full load-use stall for one cycle at pc=8
    bus.hold_pc = 1; bus.hold_if_id = 1; bus.bubble_sel = 1;
    cyc();
    chk("t2_pc", bus.pc, 32'h8);
    chk("t2_pc4", bus.if_id_pc4, 32'h8);
    chk("t2_ctrl", {22'b0, bus.id_ex_ctrl}, 32'h0);
    chk("t2_state", {30'b0, bus.state}, 32'd1);
    bus.hold_pc = 0; bus.hold_if_id = 0; bus.bubble_sel = 0;
    cyc();
    chk("t2_pc_c", bus.pc, 32'hC);
    chk("t2_run", {30'b0, bus.state}, 32'd0);

    // 3: taken branch at pc=C
    bus.branch_taken = 1; bus.branch_target = 32'h40;
    cyc();
    chk("t3_pc", bus.pc, 32'h40);
    chk("t3_instr", bus.if_id_instr, 32'h0);
    chk("t3_valid", {31'b0, bus.if_id_valid}, 32'h0);
    chk("t3_state", {30'b0, bus.state}, 32'd2);
    bus.branch_taken = 0;
    cyc();
    chk("t3_pc44", bus.pc, 32'h44);
    chk("t3_run", {30'b0, bus.state}, 32'd0);

    // 4: branch under hold is ignored; IF/ID reloads the same word
    bus.branch_taken = 1; bus.branch_target = 32'h80; bus.hold_pc = 1;
    cyc();
    chk("t4_pc", bus.pc, 32'h44);
    chk("t4_state", {30'b0, bus.state}, 32'd1);
    chk("t4_valid", {31'b0, bus.if_id_valid}, 32'h1);
    chk("t4_pc4", bus.if_id_pc4, 32'h48);
    bus.branch_taken = 0; bus.hold_pc = 0;
    cyc();
    chk("t4_pc48", bus.pc, 32'h48);

    // 5: six-cycle stall run
    bus.hold_pc = 1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("t5_err", {31'b0, bus.stall_err}, (i >= 5) ? 32'h1 : 32'h0);
    end
    chk("t5_pc", bus.pc, 32'h48);
    bus.hold_pc = 0;
    cyc();
    chk("t5_err_sticky", {31'b0, bus.stall_err}, 32'h1);
    chk("t5_pc4c", bus.pc, 32'h4C);

    // PC wrap at the top of the address space
    bus.branch_taken = 1; bus.branch_target = 32'hFFFF_FFFC;
    cyc();
    chk("wrap_pc_top", bus.pc, 32'hFFFF_FFFC);
    bus.branch_taken = 0;
    cyc();
    chk("wrap_pc", bus.pc, 32'h0);
    chk("wrap_pc4", bus.if_id_pc4, 32'h0);

    // 6: reset in the middle of a stall at pc=20
    bus.branch_taken = 1; bus.branch_target = 32'h1C;
    cyc();
    bus.branch_taken = 0;
    cyc();
    bus.hold_pc = 1;
    cyc(); cyc();
    chk("t6_pc_pre", bus.pc, 32'h20);
    chk("t6_err_pre", {31'b0, bus.stall_err}, 32'h1);
`ifdef PERF_CNT_EN
    chk("perf_stalls_lit", bus.perf_stalls, 32'd10);
    chk("perf_flushes_lit", bus.perf_flushes, 32'd3);
`endif
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    chk("t6_pc", bus.pc, 32'h0);
    chk("t6_valid", {31'b0, bus.if_id_valid}, 32'h0);
    chk("t6_err", {31'b0, bus.stall_err}, 32'h0);
    chk("t6_state", {30'b0, bus.state}, 32'd0);
`ifdef PERF_CNT_EN
    chk("t6_perf_stalls", bus.perf_stalls, 32'd0);
    chk("t6_perf_flushes", bus.perf_flushes, 32'd0);
`endif
    bus.hold_pc = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    chk("t6_restart_pc", bus.pc, 32'h4);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
